branch_resolve_unit: RTL
========================

Name: branch_resolve_unit

Overview:
Resolves conditional branches at EX and closes the loop with the IF-stage dynamic predictor. Compares the prediction carried down the pipeline against the actual outcome. On a mispredict it issues a one-cycle flush and a redirect PC. Every resolved branch is queued as an update to the predictor's history/target table, and branch/mispredict statistics are kept for predictor experiments.

Parameters:
ADDR_W, 32, PC/target width
IDX_BITS, 4, predictor table index width; index = pc[IDX_BITS+1:2]
FIFO_DEPTH, 4, update queue entries (power of 2, >=2)
CNT_W, 16, statistics counter width

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
ex_valid  in  1  EX stage holds a valid instruction this cycle
ex_is_branch  in  1  instruction is a conditional branch
ex_pc  in  ADDR_W  branch PC
ex_pred_taken  in  1  prediction made in IF
ex_pred_target  in  ADDR_W  target predicted in IF (don't-care if not predicted taken)
ex_taken  in  1  actual outcome
ex_target  in  ADDR_W  actual taken target
flush  out  1  squash IF/ID, redirect fetch
redirect_pc  out  ADDR_W  correct next PC, valid while flush=1
upd_valid  out  1  update entry available to predictor
upd_ready  in  1  predictor accepts update
upd_idx  out  IDX_BITS  table index
upd_taken  out  1  actual outcome
upd_target  out  ADDR_W  actual target
branch_cnt  out  CNT_W  resolved branches, saturating
mispred_cnt  out  CNT_W  mispredicts, saturating
drop_cnt  out  CNT_W  updates dropped on full queue, saturating

Behaviour:
- Reset: synchronous, active-high; one clock; wins over all other activity, including mid-flush and mid-handshake. flush=0, redirect_pc=0, upd_valid=0, queue emptied, all counters=0.
- Resolve event R: ex_valid & ex_is_branch & ~flush.
- Wrong-path rule: any input presented while flush=1 is ignored. No count, no update, no flush.
- Mispredict M (when R):
  - (ex_pred_taken != ex_taken), or
  - (ex_taken & ex_pred_taken & ex_pred_target != ex_target).
- Flush timing: flush and redirect_pc are registered. flush=1 for exactly the one cycle after an M. redirect_pc = ex_taken ? ex_target : ex_pc+4, computed mod 2^ADDR_W.
- Consecutive M: back-to-back M is impossible by the wrong-path rule.
- Counters: on R, branch_cnt+1; on M, mispred_cnt+1. All counters saturate at 2^CNT_W-1 with no wrap.
- Update queue: FIFO of {idx, taken, target}.
  - Push on R.
  - Pop when upd_valid & upd_ready.
  - upd_valid = queue non-empty. Head fields are stable while upd_valid=1 and upd_ready=0.
  - An entry pushed into an empty queue appears on upd_* the next cycle; there is no same-cycle bypass.
- Queue boundaries:
  - Full and no pop in the same cycle: the push is dropped and drop_cnt+1. Flush and statistics still proceed.
  - Full with a pop in the same cycle: the push is accepted and occupancy is unchanged.
  - Empty: upd_ready is ignored.
  - Pointers wrap modulo FIFO_DEPTH; order is strictly FIFO.
- Non-branch or invalid inputs: no effect.

Test Plan:
- Correct not-taken: pc=0x40, pred 0, actual 0 -> flush stays 0; branch_cnt=1; next cycle upd_valid=1, upd_idx=0x0, upd_taken=0.
- Direction mispredict: pc=0x100, pred 0, actual taken, target 0x200 -> next cycle flush=1 for 1 cycle, redirect_pc=0x200; mispred_cnt=1.
- Target mispredict: pred taken to 0x300, actual taken to 0x380 -> flush=1, redirect_pc=0x380. Also pred taken, actual not-taken at pc=0x1C -> redirect_pc=0x20.
- Wrong-path squash: mispredict at cycle t; at t+1 (flush=1) present another valid branch -> no counter change, no queue push.
- Backpressure: upd_ready=0, 5 consecutive correct branches -> 4 queued, drop_cnt=1. Then upd_ready=1 -> 4 pops in original PC order, upd_valid falls. Full + pop + push in the same cycle -> no drop.
- Reset mid-operation: assert rst while flush=1 and queue holds 3 entries -> next cycle flush=0, upd_valid=0, all counters 0.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: EX-stage branch resolution with mispredict flush, predictor update queue and statistics
module branch_resolve_unit #(
  parameter int ADDR_W = 32,
  parameter int IDX_BITS = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid,
  input  logic                ex_is_branch,
  input  logic [ADDR_W-1:0]   ex_pc,
  input  logic                ex_pred_taken,
  input  logic [ADDR_W-1:0]   ex_pred_target,
  input  logic                ex_taken,
  input  logic [ADDR_W-1:0]   ex_target,
  output logic                flush,
  output logic [ADDR_W-1:0]   redirect_pc,
  output logic                upd_valid,
  input  logic                upd_ready,
  output logic [IDX_BITS-1:0] upd_idx,
  output logic                upd_taken,
  output logic [ADDR_W-1:0]   upd_target,
  output logic [CNT_W-1:0]    branch_cnt,
  output logic [CNT_W-1:0]    mispred_cnt,
  output logic [CNT_W-1:0]    drop_cnt
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = IDX_BITS + 1 + ADDR_W;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic resolve, mispred, pop, full, push, drop;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    return c + CNT_W'(en && c != '1);
  endfunction
  always_comb begin
    resolve = ex_valid & ex_is_branch & ~flush;
    mispred = resolve & ((ex_pred_taken ^ ex_taken) | (ex_taken & ex_pred_taken & (ex_pred_target != ex_target)));
    pop = upd_valid & upd_ready;
    full = count == (PW+1)'(FIFO_DEPTH);
    push = resolve & (~full | pop);
    drop = resolve & full & ~pop;
  end
  assign upd_valid = count != '0;
  assign {upd_idx, upd_taken, upd_target} = mem[rd_ptr];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {ex_pc[IDX_BITS+1:2], ex_taken, ex_target};
  always_ff @(posedge clk) begin
    if (rst) begin
      flush <= 1'b0;
      redirect_pc <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      branch_cnt <= '0;
      mispred_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      flush <= mispred;
      if (mispred) redirect_pc <= ex_taken ? ex_target : ex_pc + ADDR_W'(4);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      branch_cnt <= sat_inc(branch_cnt, resolve);
      mispred_cnt <= sat_inc(mispred_cnt, mispred);
      drop_cnt <= sat_inc(drop_cnt, drop);
    end
  end
endmodule
